// File: rtl/pifo_sreg_queue.sv
// Single-node push-in-first-out priority queue kept as a sorted shift-register array.
// Slot 0 is always the head; equal priorities keep arrival order.
module pifo_sreg_queue #(
    parameter int PTW   = 16,
    parameter int MTW   = 32,
    parameter int DEPTH = 8,
    parameter int CTW   = 4,
    parameter int MODE  = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [MTW+PTW-1:0] i_push_data,
    input  logic               i_pop,
    output logic               o_pop_valid,
    output logic [MTW+PTW-1:0] o_pop_data,
    output logic [MTW+PTW-1:0] o_head_data,
    output logic [CTW-1:0]     o_count,
    output logic               o_empty,
    output logic               o_full,
    output logic               o_drop,
    output logic               o_underflow
);
    localparam int W = MTW + PTW;

    generate
        if (DEPTH < 2 || DEPTH > 64 || (2 ** CTW) <= DEPTH) begin : g_param_check
            $fatal(1, "pifo_sreg_queue: DEPTH must be 2..64 and 2**CTW must exceed DEPTH");
        end
    endgenerate

    logic [W-1:0]     ent     [DEPTH];
    logic [DEPTH-1:0] vld;

    logic [W-1:0]     sh_ent  [DEPTH];
    logic [DEPTH-1:0] sh_vld;
    logic [W-1:0]     nxt_ent [DEPTH];
    logic [DEPTH-1:0] nxt_vld;
    logic [DEPTH-1:0] ins_mask;
    logic [PTW-1:0]   new_prio;
    logic             pop_ok;
    logic             push_ok;
    logic [CTW-1:0]   count_nxt;

    assign new_prio = i_push_data[PTW-1:0];
    assign pop_ok   = i_pop & vld[0];
    assign push_ok  = i_push & (~o_full | pop_ok);

    // Post-pop view of the array: the head is removed before the insertion point is chosen.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            sh_ent[k] = ent[k];
        end
        sh_vld = vld;
        if (pop_ok) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                sh_ent[k] = ent[k + 1];
                sh_vld[k] = vld[k + 1];
            end
            sh_vld[DEPTH-1] = 1'b0;
        end
    end

    // Thermometer mask: set on every slot the new entry beats (invalid slots always lose).
    always_comb begin
        ins_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (MODE == 0) begin
                ins_mask[k] = ~sh_vld[k] | (new_prio < sh_ent[k][PTW-1:0]);
            end else begin
                ins_mask[k] = ~sh_vld[k] | (new_prio > sh_ent[k][PTW-1:0]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            nxt_ent[k] = sh_ent[k];
        end
        nxt_vld = sh_vld;
        if (push_ok) begin
            if (ins_mask[0]) begin
                nxt_ent[0] = i_push_data;
                nxt_vld[0] = 1'b1;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (ins_mask[k]) begin
                    nxt_ent[k] = ins_mask[k-1] ? sh_ent[k-1] : i_push_data;
                    nxt_vld[k] = ins_mask[k-1] ? sh_vld[k-1] : 1'b1;
                end
            end
        end
    end

    assign count_nxt = o_count + CTW'(push_ok) - CTW'(pop_ok);

    always_ff @(posedge i_clk) begin
        ent <= nxt_ent;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld         <= '0;
            o_count     <= '0;
            o_empty     <= 1'b1;
            o_full      <= 1'b0;
            o_pop_valid <= 1'b0;
            o_pop_data  <= '0;
            o_drop      <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            vld         <= nxt_vld;
            o_count     <= count_nxt;
            o_empty     <= (count_nxt == '0);
            o_full      <= (count_nxt == CTW'(DEPTH));
            o_pop_valid <= pop_ok;
            if (pop_ok) begin
                o_pop_data <= ent[0];
            end
            o_drop      <= i_push & ~push_ok;
            o_underflow <= i_pop & ~vld[0];
        end
    end

    assign o_head_data = vld[0] ? ent[0] : '1;

endmodule

// File: tb/tb_pifo_sreg_queue.sv
// Directed bench: table of {inputs, expected outputs} for a MODE=0 DEPTH=4 queue,
// plus a hand-written max-first sequence on a second instance.
module tb_pifo_sreg_queue;
    localparam int PTW = 8;
    localparam int MTW = 8;
    localparam int W   = PTW + MTW;
    localparam int CTW = 3;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0, push0, pop0, rst1, push1, pop1;
    logic [W-1:0] din0, din1;
    logic         pv0, empty0, full0, drop0, uf0;
    logic         pv1, empty1, full1, drop1, uf1;
    logic [W-1:0] pd0, head0, pd1, head1;
    logic [CTW-1:0] cnt0, cnt1;

    pifo_sreg_queue #(.PTW(PTW), .MTW(MTW), .DEPTH(4), .CTW(CTW), .MODE(0)) dut0 (
        .i_clk(clk), .i_rst(rst0), .i_push(push0), .i_push_data(din0), .i_pop(pop0),
        .o_pop_valid(pv0), .o_pop_data(pd0), .o_head_data(head0), .o_count(cnt0),
        .o_empty(empty0), .o_full(full0), .o_drop(drop0), .o_underflow(uf0)
    );

    pifo_sreg_queue #(.PTW(PTW), .MTW(MTW), .DEPTH(4), .CTW(CTW), .MODE(1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_push(push1), .i_push_data(din1), .i_pop(pop1),
        .o_pop_valid(pv1), .o_pop_data(pd1), .o_head_data(head1), .o_count(cnt1),
        .o_empty(empty1), .o_full(full1), .o_drop(drop1), .o_underflow(uf1)
    );

    typedef struct {
        logic         rst, push, pop;
        logic [W-1:0] din;
        logic         pv;
        logic [W-1:0] pd, head;
        logic [CTW-1:0] cnt;
        logic         empty, full, drop, uf;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int row, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic pu, input logic po, input logic [W-1:0] d,
                       input logic pv, input logic [W-1:0] pd, input logic [W-1:0] hd,
                       input logic [CTW-1:0] c, input logic e, input logic f,
                       input logic dr, input logic u);
        vec_t v;
        v.rst = r; v.push = pu; v.pop = po; v.din = d; v.pv = pv; v.pd = pd; v.head = hd;
        v.cnt = c; v.empty = e; v.full = f; v.drop = dr; v.uf = u;
        vecs.push_back(v);
    endtask

    localparam logic [W-1:0] NONE = '1;

    initial begin
        //   rst push pop din      pv pd       head     cnt e  f  drop uf
        add(0, 0, 0, 16'h0000, 0, 16'h0000, NONE,    0, 1, 0, 0, 0); // idle after reset
        add(0, 0, 1, 16'h0000, 0, 16'h0000, NONE,    0, 1, 0, 0, 1); // pop on empty
        add(0, 1, 0, 16'h0A07, 0, 16'h0000, 16'h0A07, 1, 0, 0, 0, 0);
        add(0, 1, 0, 16'h0B03, 0, 16'h0000, 16'h0B03, 2, 0, 0, 0, 0);
        add(0, 1, 0, 16'h0C09, 0, 16'h0000, 16'h0B03, 3, 0, 0, 0, 0);
        add(0, 1, 0, 16'h0D03, 0, 16'h0000, 16'h0B03, 4, 0, 1, 0, 0); // tie lands behind B
        add(0, 0, 1, 16'h0000, 1, 16'h0B03, 16'h0D03, 3, 0, 0, 0, 0);
        add(0, 0, 1, 16'h0000, 1, 16'h0D03, 16'h0A07, 2, 0, 0, 0, 0);
        add(0, 0, 1, 16'h0000, 1, 16'h0A07, 16'h0C09, 1, 0, 0, 0, 0);
        add(0, 0, 1, 16'h0000, 1, 16'h0C09, NONE,    0, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0C09, NONE,    0, 1, 0, 0, 0); // pop data holds
        add(0, 1, 0, 16'h0104, 0, 16'h0C09, 16'h0104, 1, 0, 0, 0, 0);
        add(0, 1, 0, 16'h0103, 0, 16'h0C09, 16'h0103, 2, 0, 0, 0, 0);
        add(0, 1, 0, 16'h0102, 0, 16'h0C09, 16'h0102, 3, 0, 0, 0, 0);
        add(0, 1, 0, 16'h0101, 0, 16'h0C09, 16'h0101, 4, 0, 1, 0, 0);
        add(0, 1, 0, 16'h0200, 0, 16'h0C09, 16'h0101, 4, 0, 1, 1, 0); // full: dropped
        add(0, 1, 1, 16'h0200, 1, 16'h0101, 16'h0200, 4, 0, 1, 0, 0); // full push+pop
        add(0, 0, 1, 16'h0000, 1, 16'h0200, 16'h0102, 3, 0, 0, 0, 0);
        add(0, 0, 1, 16'h0000, 1, 16'h0102, 16'h0103, 2, 0, 0, 0, 0);
        add(0, 0, 1, 16'h0000, 1, 16'h0103, 16'h0104, 1, 0, 0, 0, 0);
        add(0, 0, 1, 16'h0000, 1, 16'h0104, NONE,    0, 1, 0, 0, 0);
        add(0, 1, 0, 16'h0305, 0, 16'h0104, 16'h0305, 1, 0, 0, 0, 0);
        add(0, 1, 1, 16'h0302, 1, 16'h0305, 16'h0302, 1, 0, 0, 0, 0); // no bypass
        add(0, 0, 1, 16'h0000, 1, 16'h0302, NONE,    0, 1, 0, 0, 0);
        add(0, 1, 1, 16'h0406, 0, 16'h0302, 16'h0406, 1, 0, 0, 0, 1); // push+pop on empty
        add(0, 1, 0, 16'h0501, 0, 16'h0302, 16'h0501, 2, 0, 0, 0, 0);
        add(0, 1, 0, 16'h0502, 0, 16'h0302, 16'h0501, 3, 0, 0, 0, 0);
        add(1, 1, 1, 16'h0600, 0, 16'h0000, NONE,    0, 1, 0, 0, 0); // reset wins
        add(0, 0, 0, 16'h0000, 0, 16'h0000, NONE,    0, 1, 0, 0, 0);

        rst0 = 1'b1; push0 = 1'b0; pop0 = 1'b0; din0 = '0;
        rst1 = 1'b1; push1 = 1'b0; pop1 = 1'b0; din1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            rst0 = vecs[i].rst; push0 = vecs[i].push; pop0 = vecs[i].pop; din0 = vecs[i].din;
            @(posedge clk);
            #1;
            chk("pop_valid", i, W'(pv0),    W'(vecs[i].pv));
            chk("pop_data",  i, pd0,        vecs[i].pd);
            chk("head",      i, head0,      vecs[i].head);
            chk("count",     i, W'(cnt0),   W'(vecs[i].cnt));
            chk("empty",     i, W'(empty0), W'(vecs[i].empty));
            chk("full",      i, W'(full0),  W'(vecs[i].full));
            chk("drop",      i, W'(drop0),  W'(vecs[i].drop));
            chk("underflow", i, W'(uf0),    W'(vecs[i].uf));
        end
        rst0 = 1'b0; push0 = 1'b0; pop0 = 1'b0;

        // Max-first instance: push 10, 40, 20 then expect 40, 20, 10.
        begin
            logic [W-1:0] ins [3];
            logic [W-1:0] outs [3];
            logic [W-1:0] heads [3];
            ins[0] = 16'h010A; ins[1] = 16'h0228; ins[2] = 16'h0314;
            heads[0] = 16'h010A; heads[1] = 16'h0228; heads[2] = 16'h0228;
            outs[0] = 16'h0228; outs[1] = 16'h0314; outs[2] = 16'h010A;
            for (int i = 0; i < 3; i++) begin
                push1 = 1'b1; din1 = ins[i];
                @(posedge clk);
                #1;
                chk("max_head", 100 + i, head1, heads[i]);
                chk("max_count", 100 + i, W'(cnt1), W'(i + 1));
            end
            push1 = 1'b0;
            for (int i = 0; i < 3; i++) begin
                pop1 = 1'b1;
                @(posedge clk);
                #1;
                chk("max_pop_valid", 110 + i, W'(pv1), W'(1));
                chk("max_pop_data", 110 + i, pd1, outs[i]);
            end
            pop1 = 1'b0;
            chk("max_empty", 120, W'(empty1), W'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
